// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register aliases plus the writeback-stage
// source select and FSM state encodings.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // Writeback value source
  typedef enum logic [1:0] {
    ALU  = 2'd0,
    MEM  = 2'd1,
    LINK = 2'd2,
    LUI  = 2'd3
  } wb_src_t;

  // Writeback stage control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HALTED   = 2'd2
  } wb_state_t;

  // LUI places the 16-bit immediate in the upper half of the word
  localparam int LUI_SHIFT = 16;

endpackage

// File: rtl/writeback_unit.sv
// Writeback stage: picks the register-file write value (ALU, load, link, LUI),
// stalls the datapath while a load waits for dhit, tracks halt and counts
// retired writebacks.
// Optional build macro WB_TIMEOUT_EN adds a load-wait timeout and the sticky
// wb_err output.
module writeback_unit
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wb_valid,
  input  wb_src_t          wb_src,
  input  regbits_t         wb_rd,
  input  word_t            alu_res,
  input  word_t            pc_plus4,
  input  logic [15:0]      imm16,
  input  logic             dhit,
  input  word_t            dmemload,
  input  logic             halt,
  output logic             rf_wen,
  output regbits_t         rf_wsel,
  output word_t            rf_wdat,
  output logic             wb_stall,
  output logic             halted,
  output logic [CNT_W-1:0] wb_count
`ifdef WB_TIMEOUT_EN
  ,
  output logic             wb_err
`endif
);

  wb_state_t state, next_state;
  regbits_t  pending_rd, next_pending_rd;
  logic      halt_pend, next_halt_pend;
  logic      retire;
  regbits_t  wr_rd;
  word_t     wr_data;
  word_t     imm_value;

`ifdef WB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              enter_wait;
  logic              timeout;
`endif

  assign imm_value = word_t'(imm16) << LUI_SHIFT;

  // State, pending destination, latched halt and retire counter
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pending_rd <= '0;
      halt_pend  <= 1'b0;
      wb_count   <= '0;
    end else begin
      state      <= next_state;
      pending_rd <= next_pending_rd;
      halt_pend  <= next_halt_pend;
      if (retire) wb_count <= wb_count + CNT_W'(1);
    end
  end

  // Next-state, write selection and stall/halt outputs
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    next_state      = state;
    next_pending_rd = pending_rd;
    next_halt_pend  = halt_pend;
    retire          = 1'b0;
    wr_rd           = '0;
    wr_data         = '0;
    wb_stall        = 1'b0;
    halted          = 1'b0;
`ifdef WB_TIMEOUT_EN
    enter_wait      = 1'b0;
    timeout         = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (halt) next_state = HALTED;
        if (wb_valid) begin
          if (wb_src == MEM && !dhit) begin
            // Load miss: remember rd and any halt from the same instruction
            next_state      = WAIT_MEM;
            next_pending_rd = wb_rd;
            next_halt_pend  = halt;
            wb_stall        = 1'b1;
`ifdef WB_TIMEOUT_EN
            enter_wait      = 1'b1;
`endif
          end else begin
            retire = 1'b1;
            wr_rd  = wb_rd;
            unique case (wb_src)
              ALU:     wr_data = alu_res;
              MEM:     wr_data = dmemload;
              LINK:    wr_data = pc_plus4;
              LUI:     wr_data = imm_value;
              default: wr_data = '0;
            endcase
          end
        end
      end

      WAIT_MEM: begin
        wb_stall = 1'b1;
        if (halt) next_halt_pend = 1'b1;
        if (dhit) begin
          // Load returns; a dhit coinciding with the timeout still wins
          retire          = 1'b1;
          wr_rd           = pending_rd;
          wr_data         = dmemload;
          wb_stall        = 1'b0;
          next_state      = (halt_pend || halt) ? HALTED : IDLE;
          next_halt_pend  = 1'b0;
          next_pending_rd = '0;
        end
`ifdef WB_TIMEOUT_EN
        else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on the load: no write, leave the stall state
          timeout         = 1'b1;
          next_state      = (halt_pend || halt) ? HALTED : IDLE;
          next_halt_pend  = 1'b0;
          next_pending_rd = '0;
        end
`endif
      end

      HALTED: begin
        wb_stall = 1'b1;
        halted   = 1'b1;
      end

      default: next_state = IDLE;
    endcase

    // rd=0 retires without writing; idle select/data lines are held at zero
    rf_wen  = retire && (wr_rd != '0);
    rf_wsel = rf_wen ? wr_rd : '0;
    rf_wdat = rf_wen ? wr_data : '0;
  end

`ifdef WB_TIMEOUT_EN
  // Load-wait cycle counter and sticky timeout error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      if (enter_wait)            wait_cnt <= '0;
      else if (state == WAIT_MEM) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (timeout) wb_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a table of single-cycle writebacks plus
// hand-written load-latency, halt, reset and (with WB_TIMEOUT_EN) timeout sequences.
module tb_writeback_unit;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        wb_valid;
  wb_src_t     wb_src;
  regbits_t    wb_rd;
  word_t       alu_res;
  word_t       pc_plus4;
  logic [15:0] imm16;
  logic        dhit;
  word_t       dmemload;
  logic        halt;
  logic        rf_wen;
  regbits_t    rf_wsel;
  word_t       rf_wdat;
  logic        wb_stall;
  logic        halted;
  logic [31:0] wb_count;
`ifdef WB_TIMEOUT_EN
  logic        wb_err;
`endif

  int checks = 0;
  int errors = 0;

`ifdef WB_TIMEOUT_EN
  writeback_unit #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
`else
  writeback_unit #(.TIMEOUT_CYCLES(255), .CNT_W(32)) dut (
`endif
    .CLK(CLK), .RST(RST), .wb_valid(wb_valid), .wb_src(wb_src), .wb_rd(wb_rd),
    .alu_res(alu_res), .pc_plus4(pc_plus4), .imm16(imm16), .dhit(dhit),
    .dmemload(dmemload), .halt(halt), .rf_wen(rf_wen), .rf_wsel(rf_wsel),
    .rf_wdat(rf_wdat), .wb_stall(wb_stall), .halted(halted), .wb_count(wb_count)
`ifdef WB_TIMEOUT_EN
    , .wb_err(wb_err)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    wb_src_t     src;
    regbits_t    rd;
    word_t       alu;
    word_t       pc4;
    logic [15:0] imm;
    logic        hit;
    word_t       dml;
    logic        e_wen;
    regbits_t    e_sel;
    word_t       e_dat;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input wb_src_t s, input regbits_t rd,
                       input logic h, input word_t dml, input logic hl);
    wb_valid = v;
    wb_src   = s;
    wb_rd    = rd;
    dhit     = h;
    dmemload = dml;
    halt     = hl;
  endtask

  task automatic check_wr(input string name, input logic wen, input regbits_t sel,
                          input word_t dat, input logic stall);
    check({name, ".wen"},   32'(rf_wen),   32'(wen));
    check({name, ".wsel"},  32'(rf_wsel),  32'(sel));
    check({name, ".wdat"},  rf_wdat,       dat);
    check({name, ".stall"}, 32'(wb_stall), 32'(stall));
  endtask

  initial begin
    RST = 1'b1;
    alu_res = '0; pc_plus4 = '0; imm16 = '0;
    drive(1'b0, ALU, 5'd0, 1'b0, 32'h0, 1'b0);

    vecs[0] = '{1'b1, ALU,  5'd5,  32'hDEADBEEF, 32'h0,        16'h0,    1'b0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 32'd1};
    vecs[1] = '{1'b1, LINK, 5'd31, 32'h11111111, 32'h00000104, 16'h0,    1'b0, 32'h0,        1'b1, 5'd31, 32'h00000104, 32'd2};
    vecs[2] = '{1'b1, LUI,  5'd0,  32'h22222222, 32'h0,        16'hABCD, 1'b0, 32'h0,        1'b0, 5'd0,  32'h00000000, 32'd3};
    vecs[3] = '{1'b1, LUI,  5'd3,  32'h0,        32'h0,        16'h1234, 1'b0, 32'h0,        1'b1, 5'd3,  32'h12340000, 32'd4};
    vecs[4] = '{1'b1, MEM,  5'd7,  32'h33333333, 32'h0,        16'h0,    1'b1, 32'hCAFEF00D, 1'b1, 5'd7,  32'hCAFEF00D, 32'd5};
    vecs[5] = '{1'b0, ALU,  5'd8,  32'h00000055, 32'h0,        16'h0,    1'b0, 32'h0,        1'b0, 5'd0,  32'h00000000, 32'd5};
    vecs[6] = '{1'b1, ALU,  5'd0,  32'hFFFFFFFF, 32'h0,        16'h0,    1'b0, 32'h0,        1'b0, 5'd0,  32'h00000000, 32'd6};
    vecs[7] = '{1'b1, MEM,  5'd0,  32'h0,        32'h0,        16'h0,    1'b1, 32'h87654321, 1'b0, 5'd0,  32'h00000000, 32'd7};

    // Reset state, observed before any clock edge
    #3;
    check("rst.wen",    32'(rf_wen),   32'd0);
    check("rst.stall",  32'(wb_stall), 32'd0);
    check("rst.halted", 32'(halted),   32'd0);
    check("rst.count",  wb_count,      32'd0);
`ifdef WB_TIMEOUT_EN
    check("rst.err",    32'(wb_err),   32'd0);
`endif
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Single-cycle writebacks from the table
    for (int i = 0; i < 8; i++) begin
      alu_res  = vecs[i].alu;
      pc_plus4 = vecs[i].pc4;
      imm16    = vecs[i].imm;
      drive(vecs[i].valid, vecs[i].src, vecs[i].rd, vecs[i].hit, vecs[i].dml, 1'b0);
      #1;
      check_wr($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_sel, vecs[i].e_dat, 1'b0);
      tick();
      check($sformatf("vec%0d.count", i), wb_count, vecs[i].e_cnt);
    end

    // Load with three cycles of dhit low, then data
    alu_res = 32'h44444444;
    drive(1'b1, MEM, 5'd9, 1'b0, 32'h0, 1'b0);
    #1; check_wr("ld.c1", 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    drive(1'b1, ALU, 5'd4, 1'b0, 32'h0, 1'b0);   // ignored while waiting
    #1; check_wr("ld.c2", 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    #1; check_wr("ld.c3", 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    drive(1'b0, ALU, 5'd0, 1'b1, 32'h00001234, 1'b0);
    #1; check_wr("ld.hit", 1'b1, 5'd9, 32'h00001234, 1'b0);
    tick();
    check("ld.count", wb_count, 32'd8);
    drive(1'b1, ALU, 5'd2, 1'b0, 32'h0, 1'b0);
    #1; check_wr("ld.after", 1'b1, 5'd2, 32'h44444444, 1'b0);
    tick();
    check("ld.after.count", wb_count, 32'd9);

    // Halt arriving while a load is pending
    drive(1'b1, MEM, 5'd10, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, ALU, 5'd0, 1'b0, 32'h0, 1'b1);
    #1; check_wr("hl.wait", 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    drive(1'b0, ALU, 5'd0, 1'b1, 32'h0000A5A5, 1'b0);
    #1; check_wr("hl.hit", 1'b1, 5'd10, 32'h0000A5A5, 1'b0);
    tick();
    check("hl.count", wb_count, 32'd10);
    drive(1'b1, ALU, 5'd5, 1'b0, 32'h0, 1'b0);
    #1;
    check("hl.halted", 32'(halted), 32'd1);
    check_wr("hl.noop", 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    tick();
    check("hl.halted2", 32'(halted), 32'd1);
    check("hl.count2", wb_count, 32'd10);

    // Reset leaves HALTED; then reset mid WAIT_MEM abandons the load
    RST = 1'b1;
    #1;
    check("rh.halted", 32'(halted), 32'd0);
    check("rh.count",  wb_count,    32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    drive(1'b1, MEM, 5'd12, 1'b0, 32'h0, 1'b0);
    tick();
    #1;
    RST = 1'b1;
    drive(1'b0, ALU, 5'd0, 1'b0, 32'h0, 1'b0);
    #1;
    check_wr("rw.async", 1'b0, 5'd0, 32'h0, 1'b0);
    RST = 1'b0;
    drive(1'b0, ALU, 5'd0, 1'b1, 32'h00005678, 1'b0);
    #1; check_wr("rw.hit", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    check("rw.count", wb_count, 32'd0);

`ifdef WB_TIMEOUT_EN
    // Timeout with no dhit: error after four WAIT_MEM cycles, no write
    drive(1'b1, MEM, 5'd6, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, ALU, 5'd0, 1'b0, 32'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("to.w%0d.wen", c), 32'(rf_wen), 32'd0);
      check($sformatf("to.w%0d.err", c), 32'(wb_err), 32'd0);
      tick();
    end
    check("to.err", 32'(wb_err), 32'd1);
    check("to.count", wb_count, 32'd0);
    alu_res = 32'h0BADF00D;
    drive(1'b1, ALU, 5'd1, 1'b0, 32'h0, 1'b0);
    #1; check_wr("to.idle", 1'b1, 5'd1, 32'h0BADF00D, 1'b0);
    tick();
    check("to.err.sticky", 32'(wb_err), 32'd1);

    // dhit on the fourth WAIT_MEM cycle wins over the timeout
    RST = 1'b1;
    #1;
    check("to.err.rst", 32'(wb_err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    drive(1'b1, MEM, 5'd6, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, ALU, 5'd0, 1'b0, 32'h0, 1'b0);
    tick(); tick(); tick();
    drive(1'b0, ALU, 5'd0, 1'b1, 32'h00C0FFEE, 1'b0);
    #1; check_wr("tr.hit", 1'b1, 5'd6, 32'h00C0FFEE, 1'b0);
    tick();
    check("tr.err", 32'(wb_err), 32'd0);
    check("tr.count", wb_count, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
